// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// RISC-V load/store funct3 encodings and the byte-offset width.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int OFFSET_BITS = 3;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-stage request/response handshake of the load/store unit.
// The master (execute stage) issues requests; the slave (LSU) answers with a one-cycle pulse.
interface load_store_unit_if #(
  parameter int WORDSIZE = 64
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [2:0]          req_funct3;
  logic [WORDSIZE-1:0] req_addr;
  logic [WORDSIZE-1:0] req_wdata;
  logic                resp_valid;
  logic [WORDSIZE-1:0] resp_rdata;
  logic                resp_error;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data from a memory word,
// merges store data into it, and flags misaligned or illegal accesses.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0]    word,
  input  logic [OFFSET_BITS-1:0] offset,
  input  logic [2:0]             funct3,
  input  logic                   write,
  input  logic [WORDSIZE-1:0]    wdata,
  output logic [WORDSIZE-1:0]    load_data,
  output logic [WORDSIZE-1:0]    store_word,
  output logic                   error
);
  logic [5:0]          bit_shift;
  logic [WORDSIZE-1:0] shifted;
  logic [WORDSIZE-1:0] lane_mask;
  logic [WORDSIZE-1:0] placed_mask;
  logic [WORDSIZE-1:0] placed_data;
  logic                misaligned;
  logic                illegal;

  assign bit_shift = {offset, 3'b000};

  always_comb begin
    // NOTE: every output is given a default before the case so no path infers a latch.
    load_data  = '0;
    lane_mask  = '1;
    misaligned = 1'b0;
    shifted    = word >> bit_shift;

    case (funct3)
      F3_B:    load_data = {{(WORDSIZE-8){shifted[7]}}, shifted[7:0]};
      F3_H:    load_data = {{(WORDSIZE-16){shifted[15]}}, shifted[15:0]};
      F3_W:    load_data = {{(WORDSIZE-32){shifted[31]}}, shifted[31:0]};
      F3_D:    load_data = shifted;
      F3_BU:   load_data = {{(WORDSIZE-8){1'b0}}, shifted[7:0]};
      F3_HU:   load_data = {{(WORDSIZE-16){1'b0}}, shifted[15:0]};
      F3_WU:   load_data = {{(WORDSIZE-32){1'b0}}, shifted[31:0]};
      default: load_data = '0;
    endcase

    // Low two funct3 bits encode the access size for both loads and stores.
    case (funct3[1:0])
      2'b00: begin
        lane_mask  = {{(WORDSIZE-8){1'b0}}, {8{1'b1}}};
        misaligned = 1'b0;
      end
      2'b01: begin
        lane_mask  = {{(WORDSIZE-16){1'b0}}, {16{1'b1}}};
        misaligned = offset[0];
      end
      2'b10: begin
        lane_mask  = {{(WORDSIZE-32){1'b0}}, {32{1'b1}}};
        misaligned = |offset[1:0];
      end
      default: begin
        lane_mask  = '1;
        misaligned = |offset;
      end
    endcase
  end

  assign placed_mask = lane_mask << bit_shift;
  assign placed_data = (wdata & lane_mask) << bit_shift;
  assign store_word  = (word & ~placed_mask) | placed_data;

  assign illegal = write ? funct3[2] : (funct3 == 3'b111);
  assign error   = misaligned | illegal;

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word/double requests into whole-word
// accesses on a 64-bit memory port, using read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORDSIZE = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  load_store_unit_if.slave       bus,
  output logic [WORDSIZE-1:0]    mem_addr,
  output logic [WORDSIZE-1:0]    mem_wdata,
  output logic                   mem_write_en,
  input  logic [WORDSIZE-1:0]    mem_rdata
);
  lsu_state_t          state_q, state_d;
  logic                write_q, write_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [WORDSIZE-1:0] addr_q, addr_d;
  logic [WORDSIZE-1:0] wdata_q, wdata_d;
  logic [WORDSIZE-1:0] merge_q, merge_d;
  logic [WORDSIZE-1:0] rdata_q, rdata_d;
  logic                error_q, error_d;

  logic                in_idle;
  logic                accept;
  logic                al_write;
  logic [2:0]          al_funct3;
  logic [OFFSET_BITS-1:0] al_offset;
  logic [WORDSIZE-1:0] al_wdata;
  logic [WORDSIZE-1:0] al_load;
  logic [WORDSIZE-1:0] al_store;
  logic                al_error;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle & bus.req_valid;

  // In IDLE the aligner checks the incoming request so errors and SD skip READ.
  assign al_write  = in_idle ? bus.req_write : write_q;
  assign al_funct3 = in_idle ? bus.req_funct3 : funct3_q;
  assign al_offset = in_idle ? bus.req_addr[OFFSET_BITS-1:0] : addr_q[OFFSET_BITS-1:0];
  assign al_wdata  = in_idle ? bus.req_wdata : wdata_q;

  lsu_align #(.WORDSIZE(WORDSIZE)) u_align (
    .word       (mem_rdata),
    .offset     (al_offset),
    .funct3     (al_funct3),
    .write      (al_write),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .store_word (al_store),
    .error      (al_error)
  );

  always_comb begin
    state_d  = state_q;
    write_d  = write_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    merge_d  = merge_q;
    rdata_d  = rdata_q;
    error_d  = error_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          write_d  = bus.req_write;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          if (al_error) begin
            state_d = RESP;
            rdata_d = '0;
            error_d = 1'b1;
          end else if (bus.req_write && bus.req_funct3 == F3_D) begin
            state_d = WRITE;
            merge_d = al_store;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (write_q) begin
          state_d = WRITE;
          merge_d = al_store;
        end else begin
          state_d = RESP;
          rdata_d = al_load;
          error_d = 1'b0;
        end
      end
      WRITE: begin
        state_d = RESP;
        rdata_d = '0;
        error_d = 1'b0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      funct3_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      error_q  <= error_d;
    end
  end

  // Memory strobes decode straight from the state register, so reset kills a pending write at once.
  assign mem_addr     = (state_q == READ || state_q == WRITE)
                        ? {addr_q[WORDSIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}} : '0;
  assign mem_wdata    = (state_q == WRITE) ? merge_q : '0;
  assign mem_write_en = (state_q == WRITE);

  assign bus.req_ready  = in_idle;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;

endmodule
